exception_unit: RTL

Commit-point exception arbiter that drives the CP0 register block's exception-side inputs. It samples the MEM-stage instruction's exception flags and the pending hardware interrupts, and selects one exception by fixed priority. It uses current CP0 status/cause/epc/ebase values, bypassed from a same-cycle WB mtc0, and registers the exception code, EPC source and delay-slot flag for CP0. It also issues a one-cycle pipeline flush and redirect PC.

---
 rtl/exception_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/exception_unit.sv
// Commit-point exception arbiter: picks one MEM-stage exception or interrupt by
// fixed priority, registers it for CP0 and issues a one-cycle flush/redirect.
module exception_unit #(
   parameter logic [11:0] HANDLER_OFF = 12'h180
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        inst_valid_i,
   input  logic        stall_i,
   input  logic [31:0] inst_addr_i,
   input  logic        is_in_delayslot_i,
   input  logic [6:0]  exc_flags_i,
   input  logic [31:0] cp0_status_i,
   input  logic [31:0] cp0_cause_i,
   input  logic [31:0] cp0_epc_i,
   input  logic [31:0] cp0_ebase_i,
   input  logic        wb_cp0_we_i,
   input  logic [4:0]  wb_cp0_waddr_i,
   input  logic [31:0] wb_cp0_data_i,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_addr_o,
   output logic        is_in_delayslot_o,
   output logic        flush_o,
   output logic [31:0] new_pc_o
);

   localparam logic [0:0] IDLE  = 1'b0;
   localparam logic [0:0] FLUSH = 1'b1;

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;
   localparam logic [4:0] REG_EBASE  = 5'd15;

   logic [0:0]  state_q, state_d;
   logic [31:0] excepttype_q, excepttype_d;
   logic [31:0] inst_addr_q, inst_addr_d;
   logic        delayslot_q, delayslot_d;
   logic [31:0] new_pc_q, new_pc_d;

   logic [31:0] status_eff, cause_eff, epc_eff, ebase_eff;
   logic        int_pending;
   logic [4:0]  exc_code;
   logic        exc_active;
   logic        is_eret;
   logic        take;
   logic [31:0] target;

   // A WB-stage mtc0 has not reached CP0 yet, so forward it into this decision.
   always_comb begin
      status_eff = cp0_status_i;
      cause_eff  = cp0_cause_i;
      epc_eff    = cp0_epc_i;
      ebase_eff  = cp0_ebase_i;
      if (wb_cp0_we_i) begin
         case (wb_cp0_waddr_i)
            REG_STATUS: status_eff = wb_cp0_data_i;
            REG_CAUSE:  cause_eff[9:8] = wb_cp0_data_i[9:8];
            REG_EPC:    epc_eff = wb_cp0_data_i;
            REG_EBASE:  ebase_eff = wb_cp0_data_i;
            default:    ;
         endcase
      end
   end

   assign int_pending = (|(status_eff[15:8] & cause_eff[15:8])) &
                        status_eff[0] & ~status_eff[1];

   always_comb begin
      exc_code   = 5'h00;
      exc_active = 1'b1;
      is_eret    = 1'b0;
      if (int_pending)         exc_code = 5'h01;
      else if (exc_flags_i[6]) exc_code = 5'h10;
      else if (exc_flags_i[1]) exc_code = 5'h0a;
      else if (exc_flags_i[5]) exc_code = 5'h0f;
      else if (exc_flags_i[0]) exc_code = 5'h08;
      else if (exc_flags_i[2]) exc_code = 5'h0d;
      else if (exc_flags_i[3]) exc_code = 5'h0c;
      else if (exc_flags_i[4]) begin
         exc_code = 5'h0e;
         is_eret  = 1'b1;
      end else begin
         exc_active = 1'b0;
      end
   end

   assign take   = (state_q == IDLE) & inst_valid_i & ~stall_i & exc_active;
   assign target = is_eret ? epc_eff : {ebase_eff[31:12], HANDLER_OFF};

   // FLUSH always falls back to IDLE, so capture registers are cleared whenever nothing is taken.
   always_comb begin
      state_d      = IDLE;
      excepttype_d = 32'h0;
      inst_addr_d  = 32'h0;
      delayslot_d  = 1'b0;
      new_pc_d     = 32'h0;
      if (take) begin
         state_d      = FLUSH;
         excepttype_d = {27'h0, exc_code};
         inst_addr_d  = inst_addr_i;
         delayslot_d  = is_in_delayslot_i;
         new_pc_d     = target;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= IDLE;
         excepttype_q <= 32'h0;
         inst_addr_q  <= 32'h0;
         delayslot_q  <= 1'b0;
         new_pc_q     <= 32'h0;
      end else begin
         state_q      <= state_d;
         excepttype_q <= excepttype_d;
         inst_addr_q  <= inst_addr_d;
         delayslot_q  <= delayslot_d;
         new_pc_q     <= new_pc_d;
      end
   end

   assign excepttype_o        = excepttype_q;
   assign current_inst_addr_o = inst_addr_q;
   assign is_in_delayslot_o   = delayslot_q;
   assign flush_o             = (state_q == FLUSH);
   assign new_pc_o            = new_pc_q;

endmodule
